// File: rtl/muldiv_unit_if.sv
// muldiv_pkg: RV32M operation codes from ALU control.
// muldiv_if: start/done request bus between datapath and muldiv_unit.
package muldiv_pkg;
  localparam logic [4:0] ALU_MUL    = 5'b10000;
  localparam logic [4:0] ALU_MULH   = 5'b10001;
  localparam logic [4:0] ALU_MULHSU = 5'b10010;
  localparam logic [4:0] ALU_MULHU  = 5'b10011;
  localparam logic [4:0] ALU_DIV    = 5'b10100;
  localparam logic [4:0] ALU_DIVU   = 5'b10101;
  localparam logic [4:0] ALU_REM    = 5'b10110;
  localparam logic [4:0] ALU_REMU   = 5'b10111;
endpackage

interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [4:0]      alu_function;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, alu_function,
    output operand_a, operand_b, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, alu_function,
    input  operand_a, operand_b, flush,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one bit per cycle.
// Define MULDIV_FAST_MUL_EN for single-cycle multiplies.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic     clock,
  input  logic     reset_n,
  muldiv_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_n;

  logic [5:0]      cnt;
  logic [4:0]      op;
  logic            neg;
  logic [XLEN-1:0] mag, hi, lo;
  logic [XLEN-1:0] res_q;
  logic            busy_q, done_q;

  logic [4:0]      f;
  logic [XLEN-1:0] a, b;
  logic            a_neg, b_neg;
  logic            in_neg, fast;
  logic [XLEN-1:0] a_mag, b_mag, fres;
  logic            accept, last;

  logic [XLEN:0]     sum, rs, diff;
  logic [XLEN-1:0]   s_hi, s_lo, fin;
  logic [2*XLEN-1:0] prod, prodc;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] full, fullc;
`endif

  assign f      = bus.alu_function;
  assign a      = bus.operand_a;
  assign b      = bus.operand_b;
  assign last   = (cnt == 6'd31);
  assign accept = (state != CALC) && bus.start
               && !bus.flush;

  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

`ifdef MULDIV_FAST_MUL_EN
  assign full  = {{XLEN{1'b0}}, a_mag}
               * {{XLEN{1'b0}}, b_mag};
  assign fullc = in_neg ? -full : full;
`endif

  // Decode the incoming op: operand signs and fast-path result.
  always_comb begin
    a_neg  = 1'b0;
    b_neg  = 1'b0;
    in_neg = 1'b0;
    fast   = 1'b0;
    fres   = '0;
    unique case (f)
      ALU_MUL, ALU_MULHU: ;
      ALU_MULH: begin
        a_neg  = a[XLEN-1];
        b_neg  = b[XLEN-1];
        in_neg = a[XLEN-1] ^ b[XLEN-1];
      end
      ALU_MULHSU: begin
        a_neg  = a[XLEN-1];
        in_neg = a[XLEN-1];
      end
      ALU_DIV: begin
        a_neg  = a[XLEN-1];
        b_neg  = b[XLEN-1];
        in_neg = a[XLEN-1] ^ b[XLEN-1];
        if (b == '0) begin
          fast = 1'b1;
          fres = '1;
        end else if (a == {1'b1, {(XLEN-1){1'b0}}}
                     && b == '1) begin
          fast = 1'b1;
          fres = a;
        end
      end
      ALU_DIVU: begin
        if (b == '0) begin
          fast = 1'b1;
          fres = '1;
        end
      end
      ALU_REM: begin
        a_neg  = a[XLEN-1];
        b_neg  = b[XLEN-1];
        in_neg = a[XLEN-1];
        if (b == '0) begin
          fast = 1'b1;
          fres = a;
        end else if (a == {1'b1, {(XLEN-1){1'b0}}}
                     && b == '1) begin
          fast = 1'b1;
          fres = '0;
        end
      end
      ALU_REMU: begin
        if (b == '0) begin
          fast = 1'b1;
          fres = a;
        end
      end
      default: fast = 1'b1;
    endcase
`ifdef MULDIV_FAST_MUL_EN
    if (f == ALU_MUL) begin
      fast = 1'b1;
      fres = fullc[XLEN-1:0];
    end else if (f == ALU_MULH || f == ALU_MULHSU
                 || f == ALU_MULHU) begin
      fast = 1'b1;
      fres = fullc[2*XLEN-1:XLEN];
    end
`endif
  end

  // One shift-add or restoring-divide step; op[2] marks divides.
  always_comb begin
    sum  = {1'b0, hi}
         + (lo[0] ? {1'b0, mag} : '0);
    rs   = {hi, lo[XLEN-1]};
    diff = rs - {1'b0, mag};
    s_hi = sum[XLEN:1];
    s_lo = {sum[0], lo[XLEN-1:1]};
    if (op[2]) begin
      if (!diff[XLEN]) begin
        s_hi = diff[XLEN-1:0];
        s_lo = {lo[XLEN-2:0], 1'b1};
      end else begin
        s_hi = rs[XLEN-1:0];
        s_lo = {lo[XLEN-2:0], 1'b0};
      end
    end
  end

  // Sign-correct the final step into the architectural result.
  always_comb begin
    prod  = {s_hi, s_lo};
    prodc = neg ? -prod : prod;
    fin   = neg ? -s_hi : s_hi;
    unique case (op)
      ALU_MUL:  fin = prodc[XLEN-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU:
                fin = prodc[2*XLEN-1:XLEN];
      ALU_DIV, ALU_DIVU:
                fin = neg ? -s_lo : s_lo;
      default: ;
    endcase
  end

  // Next-state logic; flush beats start and any step.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE: begin
        if (bus.flush)
          state_n = IDLE;
        else if (bus.start)
          state_n = fast ? DONE : CALC;
        else
          state_n = IDLE;
      end
      CALC: begin
        if (bus.flush)
          state_n = IDLE;
        else if (last)
          state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register with registered busy/done flags.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      busy_q <= (state_n == CALC);
      done_q <= (state_n == DONE);
    end
  end

  // Operand capture, iteration and result write-back.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt   <= '0;
      op    <= '0;
      neg   <= 1'b0;
      mag   <= '0;
      hi    <= '0;
      lo    <= '0;
      res_q <= '0;
    end else if (accept) begin
      op  <= f;
      neg <= in_neg;
      cnt <= '0;
      hi  <= '0;
      mag <= f[2] ? b_mag : a_mag;
      lo  <= f[2] ? a_mag : b_mag;
      if (fast)
        res_q <= fres;
    end else if (state == CALC && !bus.flush) begin
      hi  <= s_hi;
      lo  <= s_lo;
      cnt <= cnt + 6'd1;
      if (last)
        res_q <= fin;
    end else if (state == CALC) begin
      cnt <= '0;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit.
// Expected results are hand-computed RV32M values.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  muldiv_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  // Present a request for one edge, then scramble inputs.
  task automatic launch(input logic [4:0] f,
                        input logic [31:0] a,
                        input logic [31:0] b);
    @(negedge clk);
    bus.start        = 1'b1;
    bus.alu_function = f;
    bus.operand_a    = a;
    bus.operand_b    = b;
    @(posedge clk);
    #1;
    bus.start        = 1'b0;
    bus.alu_function = ALU_REMU;
    bus.operand_a    = $urandom;
    bus.operand_b    = $urandom;
  endtask

  // Count cycles to done; optionally pulse start at pulse_at.
  task automatic wait_done(input int pulse_at,
                           output int lat,
                           output int nb);
    lat = 0;
    nb  = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (bus.busy) nb++;
      if (bus.done) begin
        lat = c;
        break;
      end
      if (c == pulse_at) begin
        bus.start        = 1'b1;
        bus.alu_function = ALU_DIV;
        bus.operand_a    = 32'd5;
        bus.operand_b    = 32'd0;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic run_op(input string tag,
                        input logic [4:0] f,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] exp,
                        input int exp_lat);
    int lat, nb;
    launch(f, a, b);
    wait_done(0, lat, nb);
    check({tag, " result"}, bus.result, exp);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy cycles"}, nb,
          (exp_lat == 1) ? 0 : 32);
    @(negedge clk);
    check({tag, " done pulse"}, bus.done, 1'b0);
    check({tag, " hold"}, bus.result, exp);
  endtask

  initial begin
    int lat, nb, seen;
    logic [31:0] prev;
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.start        = 1'b0;
    bus.flush        = 1'b0;
    bus.alu_function = '0;
    bus.operand_a    = '0;
    bus.operand_b    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", bus.busy, 1'b0);
    check("reset done", bus.done, 1'b0);
    check("reset result", bus.result, 32'h0);
    rst_n = 1'b1;

    run_op("mul", ALU_MUL, 32'd7, 32'hFFFFFFFD,
           32'hFFFFFFEB, MUL_LAT);
    run_op("mulh", ALU_MULH, 32'h80000000,
           32'h80000000, 32'h40000000, MUL_LAT);
    run_op("mulhu", ALU_MULHU, 32'hFFFFFFFF,
           32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
    run_op("mulhsu", ALU_MULHSU, 32'hFFFFFFFF,
           32'd2, 32'hFFFFFFFF, MUL_LAT);
    run_op("div", ALU_DIV, 32'hFFFFFFF9, 32'd2,
           32'hFFFFFFFD, 33);
    run_op("rem", ALU_REM, 32'hFFFFFFF9, 32'd2,
           32'hFFFFFFFF, 33);
    run_op("divu", ALU_DIVU, 32'd100, 32'd7,
           32'd14, 33);
    run_op("remu", ALU_REMU, 32'd100, 32'd7,
           32'd2, 33);
    run_op("div0", ALU_DIV, 32'd5, 32'd0,
           32'hFFFFFFFF, 1);
    run_op("remu0", ALU_REMU, 32'd5, 32'd0,
           32'd5, 1);
    run_op("divovf", ALU_DIV, 32'h80000000,
           32'hFFFFFFFF, 32'h80000000, 1);
    run_op("removf", ALU_REM, 32'h80000000,
           32'hFFFFFFFF, 32'h0, 1);
    run_op("nonm", 5'b00011, 32'd5, 32'd6,
           32'h0, 1);

    // start while busy is ignored
    launch(ALU_DIVU, 32'd100, 32'd7);
    wait_done(5, lat, nb);
    check("busy start result", bus.result, 32'd14);
    check("busy start latency", lat, 33);
    @(negedge clk);
    check("busy start idle", bus.done, 1'b0);

    // flush at N+10, restart at N+11
    prev = bus.result;
    launch(ALU_DIVU, 32'd50, 32'd6);
    seen = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    if (bus.done) seen++;
    check("flush no done", seen, 0);
    check("flush busy", bus.busy, 1'b0);
    check("flush result", bus.result, prev);
    bus.start        = 1'b1;
    bus.alu_function = ALU_DIVU;
    bus.operand_a    = 32'd9;
    bus.operand_b    = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(0, lat, nb);
    check("restart result", bus.result, 32'd3);
    check("restart latency", lat, 33);

    // start and flush together in IDLE
    @(negedge clk);
    prev = bus.result;
    bus.start        = 1'b1;
    bus.flush        = 1'b1;
    bus.alu_function = ALU_DIV;
    bus.operand_a    = 32'd5;
    bus.operand_b    = 32'd0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    seen = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    check("start+flush activity", seen, 0);
    check("start+flush result", bus.result, prev);

    // reset in the middle of CALC
    launch(ALU_DIVU, 32'd100, 32'd7);
    for (int c = 1; c <= 20; c++) @(negedge clk);
    check("pre-reset busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid reset busy", bus.busy, 1'b0);
    check("mid reset done", bus.done, 1'b0);
    check("mid reset result", bus.result, 32'h0);
    rst_n = 1'b1;
    run_op("post reset divu", ALU_DIVU, 32'd9,
           32'd3, 32'd3, 33);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
